alu_seq: RTL and testbench

- Parametrised, handshaked, multi-cycle successor of the single-cycle 14-op ALU.
- Same one-hot 14-op control encoding; operand width set by parameter.
- Adds a real iterative multiplier (full 2*WIDTH product) and an iterative restoring divider (quotient + remainder).
- Adds status flags and valid/ready flow control. Sits between the decode/issue stage and writeback of the teaching CPU datapath.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle between the issue stage, alu_seq and writeback.
// master = producer/consumer side, slave = the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [13:0]      alu_control;
    logic [WIDTH-1:0] alu_src1;
    logic [WIDTH-1:0] alu_src2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] alu_result_hi;
    logic             ovf;
    logic             zero;
    logic             div_by_zero;

    modport master (
        output in_valid, alu_control, alu_src1, alu_src2, out_ready,
        input  in_ready, out_valid, alu_result, alu_result_hi, ovf, zero, div_by_zero
    );

    modport slave (
        input  in_valid, alu_control, alu_src1, alu_src2, out_ready,
        output in_ready, out_valid, alu_result, alu_result_hi, ovf, zero, div_by_zero
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked multi-cycle 14-op ALU: single-cycle logic/arith ops plus an iterative
// shift-add multiplier and restoring divider sharing one hi/lo work register pair.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    logic [SHW-1:0]   cnt;
    logic             op_mul;
    logic             dbz_latched;
    logic [WIDTH-1:0] work_hi, work_lo, opnd;
    logic [WIDTH-1:0] result, result_hi;
    logic             ovf_r, zero_r, dbz_r;

    logic [13:0]      ctl;
    logic [WIDTH-1:0] a, b;
    logic             accept, is_mul, is_div, multi;

    assign ctl    = bus.alu_control;
    assign a      = bus.alu_src1;
    assign b      = bus.alu_src2;
    assign accept = bus.in_valid & (state == IDLE);
    assign is_mul = ~(ctl[0] | ctl[1]) & ctl[2];
    assign is_div = ~(ctl[0] | ctl[1] | ctl[2]) & ctl[3];
    assign multi  = is_mul | is_div;

    // Single-cycle path; add wins over sub for the invert/carry choice.
    logic             use_sub;
    logic [WIDTH-1:0] b_eff, sum;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;
    logic [SHW-1:0]   shamt;

    assign use_sub = ctl[1] & ~ctl[0];
    assign b_eff   = use_sub ? ~b : b;
    assign sum     = a + b_eff + WIDTH'(use_sub);
    assign shamt   = a[SHW-1:0];

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        if (ctl[0] | ctl[1]) begin
            sc_res = sum;
            sc_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else if (ctl[2] | ctl[3]) begin
            sc_res = '0;
        end else if (ctl[4]) begin
            sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        end else if (ctl[5]) begin
            sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
        end else if (ctl[6]) begin
            sc_res = a & b;
        end else if (ctl[7]) begin
            sc_res = ~(a | b);
        end else if (ctl[8]) begin
            sc_res = a | b;
        end else if (ctl[9]) begin
            sc_res = a ^ b;
        end else if (ctl[10]) begin
            sc_res = b << shamt;
        end else if (ctl[11]) begin
            sc_res = b >> shamt;
        end else if (ctl[12]) begin
            sc_res = $signed(b) >>> shamt;
        end else if (ctl[13]) begin
            sc_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
        end
    end

    // One iteration step. Mul: {hi,lo} shifts right, multiplicand added into hi.
    // Div: {rem,quot} shifts left, quotient bit enters at lo[0].
    logic [WIDTH:0]   msum, shifted, diff;
    logic             ge;
    logic [WIDTH-1:0] it_hi, it_lo;

    always_comb begin
        msum    = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
        shifted = {work_hi, work_lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        ge      = ~diff[WIDTH];
        if (op_mul) begin
            it_hi = msum[WIDTH:1];
            it_lo = {msum[0], work_lo[WIDTH-1:1]};
        end else begin
            it_hi = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            it_lo = {work_lo[WIDTH-2:0], ge};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = multi ? BUSY : DONE;
            BUSY: if (cnt == LAST) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            op_mul      <= 1'b0;
            dbz_latched <= 1'b0;
            work_hi     <= '0;
            work_lo     <= '0;
            opnd        <= '0;
            result      <= '0;
            result_hi   <= '0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt <= '0;
                    if (multi) begin
                        op_mul      <= is_mul;
                        dbz_latched <= is_div & (b == '0);
                        work_hi     <= '0;
                        work_lo     <= is_mul ? b : a;
                        opnd        <= is_mul ? a : b;
                    end else begin
                        result    <= sc_res;
                        result_hi <= '0;
                        ovf_r     <= sc_ovf;
                        zero_r    <= (sc_res == '0);
                        dbz_r     <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt     <= cnt + 1'b1;
                    work_hi <= it_hi;
                    work_lo <= it_lo;
                    if (cnt == LAST) begin
                        result    <= it_lo;
                        result_hi <= it_hi;
                        ovf_r     <= 1'b0;
                        zero_r    <= (it_lo == '0);
                        dbz_r     <= dbz_latched;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_result    = result;
    assign bus.alu_result_hi = result_hi;
    assign bus.ovf           = ovf_r;
    assign bus.zero          = zero_r;
    assign bus.div_by_zero   = dbz_r;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=32): latency, results, flags, backpressure, reset.
module tb_alu_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive an op and hold in_valid across the accept edge.
    task automatic start_op(input logic [13:0] c, input logic [W-1:0] s1, input logic [W-1:0] s2);
        bus.alu_control = c;
        bus.alu_src1    = s1;
        bus.alu_src2    = s2;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Latency counts 1 for the cycle right after the accept edge.
    task automatic wait_done(output int lat, output bit rdy_seen);
        lat = 1;
        rdy_seen = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [13:0] c,
                          input logic [W-1:0] s1, input logic [W-1:0] s2,
                          input logic [W-1:0] e_lo, input logic [W-1:0] e_hi,
                          input logic e_ovf, input logic e_zero, input logic e_dbz,
                          input int e_lat);
        int lat;
        bit rdy_seen;
        start_op(c, s1, s2);
        wait_done(lat, rdy_seen);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(e_lat));
        check({tag, "_lo"}, 64'(bus.alu_result), 64'(e_lo));
        check({tag, "_hi"}, 64'(bus.alu_result_hi), 64'(e_hi));
        check({tag, "_flags"}, 64'({bus.ovf, bus.zero, bus.div_by_zero}),
              64'({e_ovf, e_zero, e_dbz}));
        if (e_lat > 1) check({tag, "_busy_ready"}, 64'(rdy_seen), 64'd0);
        release_result();
        check({tag, "_rel_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_rel_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_res"}, {bus.alu_result_hi, bus.alu_result}, 64'd0);
        check({tag, "_flags"}, 64'({bus.ovf, bus.zero, bus.div_by_zero}), 64'd0);
    endtask

    initial begin
        logic [W-1:0] held_lo, held_hi;
        int lat;
        bit rdy_seen;

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_control = '0;
        bus.alu_src1 = '0;
        bus.alu_src2 = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_cleared("reset");

        //     tag      control     src1          src2          lo            hi            ovf  zero dbz lat
        run_op("add",   14'h0001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        1'b1, 1'b0, 1'b0, 1);
        run_op("sub",   14'h0002, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        1'b1, 1'b0, 1'b0, 1);
        run_op("mul",   14'h0004, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33);
        run_op("mul2",  14'h0004, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 33);
        run_op("div",   14'h0008, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0, 33);
        run_op("div0",  14'h0008, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b0, 1'b0, 1'b1, 33);
        run_op("slt",   14'h0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0,        1'b0, 1'b0, 1'b0, 1);
        run_op("sltu",  14'h0020, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        1'b0, 1'b1, 1'b0, 1);
        run_op("nor",   14'h0080, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1);
        run_op("xor",   14'h0200, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0,        1'b0, 1'b0, 1'b0, 1);
        run_op("sll",   14'h0400, 32'h00000021, 32'h00000003, 32'h00000006, 32'h0,        1'b0, 1'b0, 1'b0, 1);
        run_op("sra",   14'h1000, 32'h00000024, 32'h80000000, 32'hF8000000, 32'h0,        1'b0, 1'b0, 1'b0, 1);
        run_op("lui",   14'h2000, 32'h0,        32'h1234ABCD, 32'hABCD0000, 32'h0,        1'b0, 1'b0, 1'b0, 1);
        run_op("none",  14'h0000, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h0,        1'b0, 1'b1, 1'b0, 1);
        run_op("addsub",14'h0003, 32'd5,        32'd3,        32'd8,        32'h0,        1'b0, 1'b0, 1'b0, 1);
        run_op("andmul",14'h0044, 32'd6,        32'd7,        32'd42,       32'h0,        1'b0, 1'b0, 1'b0, 33);

        // Backpressure: DONE holds outputs while out_ready is low.
        start_op(14'h0008, 32'd1000, 32'd33);
        wait_done(lat, rdy_seen);
        held_lo = bus.alu_result;
        held_hi = bus.alu_result_hi;
        check("bp_lo", 64'(held_lo), 64'd30);
        check("bp_hi", 64'(held_hi), 64'd10);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold", {bus.alu_result_hi, bus.alu_result}, {held_hi, held_lo});
            check("bp_state", 64'({bus.out_valid, bus.in_ready}), 64'b10);
        end
        release_result();
        check("bp_ready_after", 64'(bus.in_ready), 64'd1);
        start_op(14'h0100, 32'h0000F000, 32'h0000000F);
        check("bp_next_valid", 64'(bus.out_valid), 64'd1);
        check("bp_next_res", 64'(bus.alu_result), 64'h0000F00F);
        release_result();

        // Reset in the middle of a divide discards it.
        start_op(14'h0008, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_cleared("mid_reset");
        run_op("post_reset_add", 14'h0001, 32'd2, 32'd3, 32'd5, 32'h0, 1'b0, 1'b0, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
